// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SIGN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opb;
  logic                 r_is_div;
  logic                 r_neg_lo;
  logic                 r_neg_hi;
  logic                 r_dz;

  logic                 w_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_abs;
  logic [WIDTH-1:0]     w_b_abs;
  logic                 w_accept;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  // Operands are converted to magnitudes up front; the most negative value maps to 2^(WIDTH-1).
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -a : a;
  assign w_b_abs  = w_b_neg ? -b : b;
  assign w_accept = (r_state == S_IDLE) && start && !flush;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_a_abs} * {{WIDTH{1'b0}}, w_b_abs};
`endif

  // Shift-add step: multiplier sits in the low half of r_acc and shifts out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: partial remainder in the high half, dividend/quotient bits in the low half.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = w_rem_sh >= {1'b0, r_opb};
  assign w_diff     = r_acc[2*WIDTH-2:WIDTH-1] - r_opb;
  assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                           : {r_acc[2*WIDTH-2:0], 1'b0};

  assign w_prod_fix = r_neg_lo ? -r_acc : r_acc;
  assign w_quo      = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      w_res_lo = r_dz ? '1 : (r_neg_lo ? -w_quo : w_quo);
      w_res_hi = r_neg_hi ? -w_rem : w_rem;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start && !flush) w_next = (FAST_MUL && !op[1]) ? S_SIGN : S_RUN;
      S_RUN: begin
        if (flush)                              w_next = S_IDLE;
        else if (r_count == CW'(WIDTH - 1))     w_next = S_SIGN;
      end
      S_SIGN:  w_next = flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (w_accept) begin
            r_count  <= '0;
            r_is_div <= op[1];
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= op[1] & w_a_neg;
            r_dz     <= op[1] & (b == '0);
            if (op[1]) begin
              r_acc <= {{WIDTH{1'b0}}, w_a_abs};
              r_opb <= w_b_abs;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              r_acc <= w_fast_prod;
`else
              r_acc <= {{WIDTH{1'b0}}, w_b_abs};
`endif
              r_opb <= w_a_abs;
            end
          end
        end
        S_RUN: begin
          if (!flush) begin
            r_count <= r_count + 1'b1;
            r_acc   <= r_is_div ? w_div_next : w_mul_next;
          end
        end
        S_SIGN: begin
          if (!flush) begin
            hi <= w_res_hi;
            lo <= w_res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign div_zero = done & r_dz;

endmodule
